led_pattern_player: RTL and testbench



---
 rtl/led_pattern_player.sv | 173 +++++++++++++++++
 tb/tb_led_pattern_player.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// rtl/led_pattern_player.sv - sequential LED pattern playback from a sync-read pattern memory
// Optional blank gap between steps: define LED_PLAYER_BLANK_GAP_EN.
module led_pattern_player #(
    parameter int LED_W      = 4,
    parameter int ADDR_W     = 4,
    parameter int HOLD_TICKS = 3,
    parameter int GAP_TICKS  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              tick,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LED_W-1:0]  mem_rdata,
    output logic [LED_W-1:0]  led,
    output logic [ADDR_W-1:0] step,
    output logic              busy,
    output logic              done
);

    if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold
        $error("HOLD_TICKS out of range 1..255");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap
        $error("GAP_TICKS out of range 1..255");
    end

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
`ifdef LED_PLAYER_BLANK_GAP_EN
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SHOW,
`ifdef LED_PLAYER_BLANK_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        hold_q, hold_d;
    logic              in_busy_state;

    assign in_busy_state = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        step_d      = step_q;
        mem_addr_d  = mem_addr_q;
        last_d      = last_q;
        mem_rd_en_d = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        hold_d      = hold_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !stop) begin
                    last_d      = last_idx;
                    step_d      = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                led_d   = mem_rdata;
                hold_d  = 8'd0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        // Last-step check comes first, so step never wraps.
                        if (step_q == last_q) begin
                            led_d   = '0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            step_d = step_q + 1'b1;
`ifdef LED_PLAYER_BLANK_GAP_EN
                            led_d   = '0;
                            hold_d  = 8'd0;
                            state_d = S_GAP;
`else
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = step_q + 1'b1;
                            state_d     = S_FETCH;
`endif
                        end
                    end else if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
`ifdef LED_PLAYER_BLANK_GAP_EN
            S_GAP: begin
                if (tick) begin
                    if (hold_q == GAP_LAST) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = step_q;
                        state_d     = S_FETCH;
                    end else if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident start.
        if (stop && in_busy_state) begin
            state_d     = S_IDLE;
            led_d       = '0;
            mem_rd_en_d = 1'b0;
            step_d      = '0;
            done_d      = 1'b0;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            led_q       <= '0;
            step_q      <= '0;
            mem_addr_q  <= '0;
            last_q      <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            step_q      <= step_d;
            mem_addr_q  <= mem_addr_d;
            last_q      <= last_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign led       = led_q;
    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// tb/tb_led_pattern_player.sv - scoreboard and vector-table bench for led_pattern_player
module tb_led_pattern_player;

    localparam int LED_W  = 4;
    localparam int ADDR_W = 4;
    localparam int HOLD   = 3;
    localparam int GAP    = 2;
    localparam int TICK_P = 4;
`ifdef LED_PLAYER_BLANK_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic tick_gen = 1'b0;
    logic tick_man = 1'b0;
    logic tick_en = 1'b0;
    logic tick;
    logic [ADDR_W-1:0] last_idx = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [LED_W-1:0]  mem_rdata = '0;
    logic [LED_W-1:0]  led;
    logic [ADDR_W-1:0] step;
    logic              busy;
    logic              done;

    logic [LED_W-1:0] mem [16];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_addr[$];
    int exp_led[$];
    int rd_count = 0;
    int gap_count = 0;
    int show_ticks = 0;
    int gap_ticks = 0;
    bit in_show = 0;
    bit in_gap = 0;
    bit rd_d1 = 0;
    bit rd_d2 = 0;

    assign tick = tick_gen | tick_man;

    led_pattern_player #(
        .LED_W(LED_W), .ADDR_W(ADDR_W), .HOLD_TICKS(HOLD), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .last_idx(last_idx), .tick(tick), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .led(led),
        .step(step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        tick_gen = tick_en && (cyc % TICK_P == 0);
    end

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: read order, displayed pattern, hold and gap tick counts.
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_d1 = 0; rd_d2 = 0; in_show = 0; in_gap = 0;
        end else begin
            if (mem_rd_en) begin
                rd_count++;
                if (exp_addr.size() == 0) check("unexpected_read", int'(mem_addr), -1);
                else begin
                    int e;
                    e = exp_addr.pop_front();
                    check("rd_addr", int'(mem_addr), e);
                    check("rd_step", int'(step), e);
                end
            end
            if (in_gap) begin
                if (!busy) in_gap = 0;
                else if (mem_rd_en) begin
                    check("gap_ticks", gap_ticks, GAP);
                    gap_count++;
                    in_gap = 0;
                end else if (tick) gap_ticks++;
            end
            if (in_show) begin
                if (!busy && !done) in_show = 0;
                else if (mem_rd_en || done || led == '0) begin
                    check("hold_ticks", show_ticks, HOLD);
                    in_show = 0;
                    if (busy && led == '0 && !mem_rd_en) begin
                        in_gap = 1;
                        gap_ticks = tick ? 1 : 0;
                    end
                end else if (tick) show_ticks++;
            end
            if (rd_d2 && busy) begin
                if (exp_led.size() == 0) check("unexpected_led", int'(led), -1);
                else check("led_pattern", int'(led), exp_led.pop_front());
                in_show = 1;
                show_ticks = tick ? 1 : 0;
            end
            rd_d2 = rd_d1;
            rd_d1 = mem_rd_en;
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int li);
        for (int i = 0; i <= li; i++) begin
            exp_addr.push_back(i);
            exp_led.push_back(int'(mem[i]));
        end
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_led.delete();
    endtask

    task automatic do_start(input int li);
        step_cyc();
        last_idx = ADDR_W'(li);
        start = 1'b1;
        push_exp(li);
        step_cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, int'(done), 1);
    endtask

    task automatic wait_step(input int s, input int l, input string name);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (int'(step) == s && int'(led) == l) break;
        end
        check(name, int'(int'(step) == s && int'(led) == l), 1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_led"}, int'(led), 0);
        check({name, "_step"}, int'(step), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_rd_en"}, int'(mem_rd_en), 0);
    endtask

    typedef struct {
        int last;
        int exp_reads;
        int exp_gaps;
        int exp_step;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int rd0;
        int g0;
        int held;

        vecs[0] = '{9, 10, 9 * GAP_EN, 9};
        vecs[1] = '{0, 1, 0, 0};
        vecs[2] = '{15, 16, 15 * GAP_EN, 15};
        vecs[3] = '{3, 4, 3 * GAP_EN, 3};
        for (int i = 0; i < 16; i++) mem[i] = (i < 15) ? LED_W'(i + 1) : 4'h5;

        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_addr", int'(mem_addr), 0);
        step_cyc();
        reset_n = 1'b1;

        // Start latency and ignored ticks in FETCH/LATCH, driven by hand.
        step_cyc();
        last_idx = 4'd9;
        start = 1'b1;
        push_exp(9);
        @(negedge clk);
        check("lat_T_rd_en", int'(mem_rd_en), 0);
        step_cyc();
        start = 1'b0;
        tick_man = 1'b1;
        @(negedge clk);
        check("lat_T1_rd_en", int'(mem_rd_en), 1);
        check("lat_T1_addr", int'(mem_addr), 0);
        check("lat_T1_busy", int'(busy), 1);
        step_cyc();
        @(negedge clk);
        check("lat_T2_rd_en", int'(mem_rd_en), 0);
        check("lat_T2_led", int'(led), 0);
        step_cyc();
        tick_man = 1'b0;
        @(negedge clk);
        check("lat_T3_led", int'(led), 1);
        repeat (2) begin
            step_cyc(); tick_man = 1'b1;
            step_cyc(); tick_man = 1'b0;
        end
        @(negedge clk);
        check("hold2_rd_en", int'(mem_rd_en), 0);
        check("hold2_led", int'(led), 1);
        step_cyc(); tick_man = 1'b1;
        step_cyc(); tick_man = 1'b0;
        @(negedge clk);
        check("hold3_rd_en", int'(mem_rd_en), 1);
        check("hold3_addr", int'(mem_addr), 1);
        step_cyc(); stop = 1'b1;
        step_cyc(); stop = 1'b0;
        @(negedge clk);
        check_idle("stop_latch");
        flush();

        // Stop during step 4 display.
        tick_en = 1'b1;
        do_start(9);
        wait_step(4, 5, "reach_step4");
        step_cyc(); stop = 1'b1;
        step_cyc(); stop = 1'b0;
        @(negedge clk);
        check_idle("stop_step4");
        flush();

        // Start and stop together from IDLE.
        rd0 = rd_count;
        step_cyc();
        last_idx = 4'd9; start = 1'b1; stop = 1'b1;
        step_cyc();
        start = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);
        check("start_stop_reads", rd_count - rd0, 0);
        check("start_stop_busy", int'(busy), 0);

        // Vector table of full playbacks.
        for (int v = 0; v < 4; v++) begin
            rd0 = rd_count;
            g0 = gap_count;
            do_start(vecs[v].last);
            wait_done("vec_done_seen");
            step_cyc();
            @(negedge clk);
            check("vec_done", int'(done), 1);
            check("vec_busy", int'(busy), 0);
            check("vec_led", int'(led), 0);
            check("vec_step", int'(step), vecs[v].exp_step);
            check("vec_reads", rd_count - rd0, vecs[v].exp_reads);
            check("vec_gaps", gap_count - g0, vecs[v].exp_gaps);
            check("vec_queue_left", exp_addr.size() + exp_led.size(), 0);
            if (v == 0) begin
                held = 0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (done && !busy && led == '0) held++;
                end
                check("done_sticky_50", held, 50);
            end
        end

        // Stop in DONE leaves done set.
        step_cyc(); stop = 1'b1;
        step_cyc(); stop = 1'b0;
        @(negedge clk);
        check("stop_in_done", int'(done), 1);

        // Start while busy is ignored.
        rd0 = rd_count;
        do_start(9);
        wait_step(2, 3, "reach_step2");
        step_cyc(); last_idx = 4'd0; start = 1'b1;
        step_cyc(); start = 1'b0;
        wait_done("busy_start_done_seen");
        step_cyc();
        @(negedge clk);
        check("busy_start_reads", rd_count - rd0, 10);
        check("busy_start_step", int'(step), 9);

        // Asynchronous reset during step 6.
        rd0 = rd_count;
        do_start(9);
        wait_step(6, 7, "reach_step6");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_addr", int'(mem_addr), 0);
        flush();
        step_cyc();
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_reads", rd_count - rd0, 7);
        check("post_reset_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
